lfsr_8bit: RTL and testbench

//  - Fibonacci linear-feedback shift register: free-running pseudo-random sequence generator.
//  - Parallel-loadable seed.
//  - Used as a PRBS/pattern source for test logic and scramblers.
//  - Shifts once per clk edge unless loading; state is visible directly on q.

---
 rtl/lfsr_pkg.sv | 12 +
 rtl/lfsr_8bit_if.sv | 14 +
 rtl/lfsr_feedback.sv | 12 +
 rtl/lfsr_8bit.sv | 50 +++++
 tb/tb_lfsr_8bit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and state type for the LFSR pattern generators.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    typedef logic [0:LFSR_W-1] lfsr_state_t;

    // Tap mask is in [0:W-1] order: the leftmost literal bit is q[0].
    localparam lfsr_state_t LFSR_TAPS_DEF = 8'b0001_1101;
    localparam lfsr_state_t LFSR_SEED_DEF = 8'b1000_0000;

endpackage : lfsr_pkg

// File: rtl/lfsr_8bit_if.sv
// Load/seed/state bundle between an LFSR and its user.
interface lfsr_8bit_if
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W
);
    logic             load;
    logic [0:WIDTH-1] din;
    logic [0:WIDTH-1] q;

    modport master (output load, output din, input q);
    modport slave  (input load, input din, output q);

endinterface : lfsr_8bit_if

// File: rtl/lfsr_feedback.sv
// Fibonacci feedback bit: XOR of the tapped state bits.
module lfsr_feedback #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [0:WIDTH-1] state,
    input  logic [0:WIDTH-1] taps,
    output logic             fb_c
);

    assign fb_c = ^(state & taps);

endmodule : lfsr_feedback

// File: rtl/lfsr_8bit.sv
// Parallel-loadable Fibonacci LFSR; q[0] is the input end, shifts toward higher index.
// Optional lock-up recovery from the all-zero state under `LFSR_LOCKUP_GUARD_EN.
module lfsr_8bit
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_W,
    parameter logic [0:WIDTH-1] TAPS  = LFSR_TAPS_DEF,
    parameter logic [0:WIDTH-1] SEED  = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst_n,   // active-high despite the name
    lfsr_8bit_if.slave bus
);

    logic [0:WIDTH-1] state;
    logic [0:WIDTH-1] state_nxt;
    logic             fb_c;

    lfsr_feedback #(
        .WIDTH (WIDTH)
    ) u_feedback (
        .state (state),
        .taps  (TAPS),
        .fb_c  (fb_c)
    );

    // Load beats shift; the guard only replaces a shift out of zero.
    always_comb begin
        state_nxt = {fb_c, state[0:WIDTH-2]};
        if (bus.load) begin
            state_nxt = bus.din;
        end
`ifdef LFSR_LOCKUP_GUARD_EN
        else if (state == '0) begin
            state_nxt = SEED;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.q = state;

endmodule : lfsr_8bit

// File: tb/tb_lfsr_8bit.sv
// Directed self-checking bench for lfsr_8bit; follows `LFSR_LOCKUP_GUARD_EN like the RTL.
module tb_lfsr_8bit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    lfsr_8bit_if bus ();

    lfsr_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] d);
        @(negedge clk);
        bus.load = ld;
        bus.din  = d;
    endtask

    logic [7:0] load_exp [4];
    logic [7:0] seed_exp [4];
    logic       seen     [256];
    int         ret_edge;
    int         zeros;
    int         repeats;
    logic [7:0] qv;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        load_exp = '{8'b1100_1000, 8'b1110_0100, 8'b1111_0010, 8'b1111_1001};
        seed_exp = '{8'b0100_0000, 8'b0010_0000, 8'b0001_0000, 8'b1000_1000};

        // Async reset takes effect before the first clock edge.
        rst_n    = 1'b1;
        bus.load = 1'b0;
        bus.din  = 8'h00;
        #1;
        check("reset_no_clk", 16'(bus.q), 16'(8'b1000_0000));
        step();
        check("reset_held", 16'(bus.q), 16'(8'b1000_0000));

        // Shifting from SEED.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seed_shift%0d", i), 16'(bus.q), 16'(seed_exp[i]));
        end

        // Load then shift.
        drive(1'b1, 8'b1100_1000);
        step();
        check("load_val", 16'(bus.q), 16'(load_exp[0]));
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("load_shift%0d", i), 16'(bus.q), 16'(load_exp[i]));
        end

        // Held load reloads every edge.
        drive(1'b1, 8'b1010_0101);
        step();
        check("hold_load0", 16'(bus.q), 16'(8'b1010_0101));
        step();
        check("hold_load1", 16'(bus.q), 16'(8'b1010_0101));

        // Async reset mid-sequence, with load asserted during reset.
        @(negedge clk);
        bus.load = 1'b0;
        step();
        #2;
        rst_n    = 1'b1;
        bus.load = 1'b1;
        bus.din  = 8'h55;
        #1;
        check("async_rst_mid", 16'(bus.q), 16'(8'b1000_0000));
        step();
        check("rst_ignores_load", 16'(bus.q), 16'(8'b1000_0000));
        @(negedge clk);
        rst_n    = 1'b0;
        bus.load = 1'b0;
        step();
        check("post_rst_shift", 16'(bus.q), 16'(8'b0100_0000));

        // Period: restart from SEED, expect return after exactly 255 edges.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'b1000_0000] = 1'b1;
        ret_edge = 0;
        zeros    = 0;
        repeats  = 0;
        for (int i = 1; i <= 300 && ret_edge == 0; i++) begin
            step();
            qv = bus.q;
            if (qv == 8'h00) zeros++;
            if (qv == 8'b1000_0000) begin
                ret_edge = i;
            end else begin
                if (seen[qv]) repeats++;
                seen[qv] = 1'b1;
            end
        end
        check("period", 16'(ret_edge), 16'd255);
        check("period_no_zero", 16'(zeros), 16'd0);
        check("period_no_repeat", 16'(repeats), 16'd0);

        // Zero load: lock-up without guard, recovery with it.
        drive(1'b1, 8'h00);
        step();
        check("zero_load", 16'(bus.q), 16'd0);
        @(negedge clk);
        bus.load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        step();
        check("guard_recover", 16'(bus.q), 16'(8'b1000_0000));
        step();
        check("guard_seq0", 16'(bus.q), 16'(8'b0100_0000));
        step();
        check("guard_seq1", 16'(bus.q), 16'(8'b0010_0000));
`else
        zeros = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus.q == 8'h00) zeros++;
        end
        check("zero_lockup", 16'(zeros), 16'd24);
        drive(1'b1, 8'b1100_1000);
        step();
        check("lockup_exit_load", 16'(bus.q), 16'(8'b1100_1000));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lfsr_8bit
